mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between instruction fetch (IF) and data access (MEM) in the RV32IM pipeline.
//  Arbitrates: data beats fetch. Runs the memory req/ack handshake and returns read data to the requester.
//  Drives if_stall/d_stall, which feed the hazard control unit's stall_pipeline input.
//  Discards a fetch cancelled by a taken branch/jump flush.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width; byte-strobe width is DATA_W/8
//  TIMEOUT  64  max cycles waiting for mem_ack before abort; legal range 2..65535
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  if_req     in   1        fetch request; held until if_ready
//  if_addr    in   ADDR_W   fetch address
//  if_rdata   out  DATA_W   fetch data; valid while if_ready=1
//  if_ready   out  1        one-cycle completion pulse
//  if_stall   out  1        if_req & ~if_ready
//  flush      in   1        taken branch/jump in EX; cancels the fetch
//  d_rd       in   1        data read request; held until d_ready
//  d_wr       in   1        data write request; never set together with d_rd
//  d_addr     in   ADDR_W   data address
//  d_wdata    in   DATA_W   write data
//  d_wstrb    in   DATA_W/8 byte enables for a write
//  d_rdata    out  DATA_W   read data; valid while d_ready=1
//  d_ready    out  1        one-cycle completion pulse
//  d_stall    out  1        (d_rd|d_wr) & ~d_ready
//  mem_req    out  1        memory request; held stable until mem_ack
//  mem_we     out  1        1 = write
//  mem_addr   out  ADDR_W   memory address
//  mem_wdata  out  DATA_W   memory write data
//  mem_wstrb  out  DATA_W/8 memory byte strobes (0 on reads)
//  mem_rdata  in   DATA_W   memory read data; sampled when mem_ack=1
//  mem_ack    in   1        memory completion, one cycle
//  bus_err    out  1        one-cycle pulse on timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; timeout counter 0.
//   Asserting rst_n low mid-transaction drops mem_req immediately; the access is lost.
//  FSM states: IDLE, BUSY_I, BUSY_D, DROP.
//  IDLE:
//   - d_rd|d_wr eligible -> BUSY_D.
//   - else if_req eligible and ~flush -> BUSY_I.
//   - A requester is ineligible in the cycle its own ready pulse is high.
//  Request registering: mem_* outputs are registered on the IDLE->BUSY transition.
//   mem_req rises 1 cycle after the request is sampled.
//   mem_addr/we/wdata/wstrb stay frozen until the handshake ends.
//  BUSY_I/BUSY_D with mem_ack=1:
//   - Capture mem_rdata into if_rdata/d_rdata (d_rdata = 0 on writes).
//   - mem_req->0; pulse the matching ready on the next cycle; go to IDLE.
//   - Minimum latency is request -> ready = 3 cycles when mem_ack returns on the first mem_req cycle.
//  BUSY_I with flush=1 and mem_ack=0 -> DROP.
//   - DROP keeps mem_req until mem_ack, discards the data, gives no if_ready, then goes to IDLE.
//  BUSY_I with flush=1 and mem_ack=1 -> IDLE. Data discarded; no if_ready.
//  flush has no effect on BUSY_D.
//  A data request arriving during BUSY_I/DROP waits; d_stall stays high meanwhile.
//  Timeout:
//   - The counter clears on entering a BUSY/DROP state and increments each cycle without mem_ack.
//   - At count == TIMEOUT-1 with no ack: drop mem_req, pulse bus_err, go to IDLE.
//   - The owner gets its ready pulse with rdata=0. DROP times out silently, with bus_err only.
//  mem_ack in IDLE is ignored.
//  if_stall/d_stall are combinational from the current inputs and registered ready.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined:
//   - Adds outputs if_stall_cnt[31:0] and d_stall_cnt[31:0].
//   - Each counts cycles with its stall=1. Both reset to 0 and saturate at 32'hFFFFFFFF.
//  ARB_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Fetch only, addr 0x100, mem_ack on the 1st mem_req cycle, rdata 0x00500093
//     -> if_ready 3 cycles after if_req, if_rdata=0x00500093.
//  2. if_req and d_rd same cycle, addrs 0x0/0x2000 -> mem_addr 0x2000 serviced first.
//     Then 0x0; if_stall high throughout the data access.
//  3. Fetch in flight (ack delayed 4 cycles), flush on cycle 2 -> mem_req held until ack.
//     No if_ready; the next fetch starts after IDLE.
//  4. d_wr addr 0x40, wdata 0xDEADBEEF, wstrb 4'b0011 -> mem_we=1 and fields frozen until ack.
//     Then d_ready pulse with d_rdata=0.
//  5. TIMEOUT=8, never ack a d_rd -> after 8 busy cycles mem_req=0.
//     bus_err and d_ready pulse together with d_rdata=0.
//  6. rst_n low during BUSY_D -> mem_req, d_ready and bus_err go 0 immediately.
//     After release, the held d_rd is reissued (re-arbitrated) from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data access. Data requests win over fetches. The block runs the mem_req/mem_ack
// handshake with a timeout, and returns read data through one-cycle ready pulses.
// A fetch cancelled by a flush keeps its handshake open until the memory
// acknowledges, but its data is thrown away.
// Optional feature: define ARB_PERF_CNT_EN to add saturating stall-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ready,
    output logic                  if_stall,
    input  logic                  flush,
    input  logic                  d_rd,
    input  logic                  d_wr,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ready,
    output logic                  d_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  bus_err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           if_stall_cnt,
    output logic [31:0]           d_stall_cnt
`endif
);

    localparam int          STRB_W   = DATA_W / 8;
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DROP} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_cnt;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    // Completion is recorded in a pending flag first, so the ready pulse lands
    // one cycle after the handshake closes; bus_err follows the same path so
    // it coincides with the owner's ready pulse.
    logic                r_if_pend;
    logic                r_d_pend;
    logic                r_err_pend;
    logic                r_if_ready;
    logic                r_d_ready;
    logic                r_bus_err;

    logic                w_busy;
    logic                w_timeout;
    logic                w_if_elig;
    logic                w_d_elig;
    logic                w_start_i;
    logic                w_start_d;
    logic                w_if_done;
    logic                w_d_done;
    logic                w_err;
    logic                w_clr_cnt;
    logic                w_if_stall;
    logic                w_d_stall;

    assign w_busy    = (r_state != IDLE);
    assign w_timeout = w_busy && !mem_ack && (r_cnt == LAST_CNT);

    // A requester whose completion is pending or pulsing must not be re-issued
    // while it still holds its request line.
    assign w_d_elig  = (d_rd || d_wr) && !r_d_ready && !r_d_pend;
    assign w_if_elig = if_req && !r_if_ready && !r_if_pend;

    assign w_if_stall = if_req && !r_if_ready;
    assign w_d_stall  = (d_rd || d_wr) && !r_d_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: data beats fetch; a flush turns an open fetch into DROP
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_d_elig) begin
                    w_state_next = BUSY_D;
                end else if (w_if_elig && !flush) begin
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = IDLE;
                end else if (flush) begin
                    w_state_next = DROP;
                end
            end
            BUSY_D: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            DROP: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode: which transaction starts, which owner completes, and errors
    always_comb begin
        w_start_i = 1'b0;
        w_start_d = 1'b0;
        w_if_done = 1'b0;
        w_d_done  = 1'b0;
        w_err     = 1'b0;
        w_clr_cnt = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_start_d = w_d_elig;
                w_start_i = !w_d_elig && w_if_elig && !flush;
                w_clr_cnt = 1'b1;
            end
            BUSY_I: begin
                // A flush in the completing cycle still discards the fetch
                w_if_done = (mem_ack || w_timeout) && !flush;
                w_err     = w_timeout;
                w_clr_cnt = flush && !mem_ack && !w_timeout;
            end
            BUSY_D: begin
                w_d_done = mem_ack || w_timeout;
                w_err    = w_timeout;
            end
            DROP: begin
                w_err = w_timeout;
            end
            default: ;
        endcase
    end

    // Timeout counter: zero while idle or on entering DROP, counts unacked cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_clr_cnt) begin
            r_cnt <= '0;
        end else if (!mem_ack) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Memory-side request registers, frozen for the whole handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else if (w_start_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_wr;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wr ? d_wdata : '0;
            r_mem_wstrb <= d_wr ? d_wstrb : '0;
        end else if (w_start_i) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else if (w_busy && (mem_ack || w_timeout)) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Response path: capture read data, then pulse ready/bus_err a cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_pend  <= 1'b0;
            r_d_pend   <= 1'b0;
            r_err_pend <= 1'b0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_if_pend  <= w_if_done;
            r_d_pend   <= w_d_done;
            r_err_pend <= w_err;
            r_if_ready <= r_if_pend;
            r_d_ready  <= r_d_pend;
            r_bus_err  <= r_err_pend;
            if (w_if_done) begin
                r_if_rdata <= w_timeout ? '0 : mem_rdata;
            end
            if (w_d_done) begin
                r_d_rdata <= (w_timeout || r_mem_we) ? '0 : mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_if_stall_cnt;
    logic [31:0] r_d_stall_cnt;

    // Saturating stall-cycle counters for performance profiling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_stall_cnt <= '0;
            r_d_stall_cnt  <= '0;
        end else begin
            if (w_if_stall && (r_if_stall_cnt != 32'hFFFF_FFFF)) begin
                r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
            end
            if (w_d_stall && (r_d_stall_cnt != 32'hFFFF_FFFF)) begin
                r_d_stall_cnt <= r_d_stall_cnt + 32'd1;
            end
        end
    end

    assign if_stall_cnt = r_if_stall_cnt;
    assign d_stall_cnt  = r_d_stall_cnt;
`endif

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign if_stall  = w_if_stall;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign d_stall   = w_d_stall;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (TIMEOUT=8). Directed scenarios push expected
// memory requests and responses into queues; a monitor pops and compares them
// whenever the DUT raises mem_req or a ready/bus_err pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        flush;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] d_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall), .flush(flush),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .bus_err(bus_err)
`ifdef ARB_PERF_CNT_EN
        , .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        if_rdy;
        logic        d_rdy;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    req_t  exp_req_q[$];
    resp_t exp_resp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    ack_delay = 0;   // mem_req cycles before ack; negative = never ack
    int    req_cycles = 0;

    // Memory contents returned by the responder
    function automatic logic [31:0] mem_image(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_2000: return 32'h1111_2222;
            32'h0000_0400: return 32'h00A0_0113;
            default:       return 32'hCAFE_0000 | a;
        endcase
    endfunction

    task automatic exp_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        req_t r;
        r = {we, a, wd, ws};
        exp_req_q.push_back(r);
    endtask

    task automatic exp_resp(input logic i, input logic d, input logic e, input logic [31:0] rd);
        resp_t r;
        r = {i, d, e, rd};
        exp_resp_q.push_back(r);
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = if_ready, 1 = d_ready, 2 = bus_err; cyc = cycles waited (0 if none)
    task automatic wait_pulse(input int which, input int max_cyc, input string name, output int cyc);
        cyc = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if ((which == 0 && if_ready) || (which == 1 && d_ready) || (which == 2 && bus_err)) begin
                cyc = c;
                break;
            end
        end
        if (cyc == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no pulse within %0d cycles", name, max_cyc);
        end
    endtask

    // Memory responder: acks after ack_delay cycles of mem_req
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (ack_delay >= 0 && req_cycles == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_image(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'h0BAD_0BAD;
                end
                req_cycles++;
            end else begin
                mem_ack    = 1'b0;
                mem_rdata  = '0;
                req_cycles = 0;
            end
        end
    end

    // Monitor: checks each new memory request, frozen fields, and every pulse
    initial begin
        req_t  got_req;
        req_t  held;
        req_t  e_req;
        resp_t got_resp;
        resp_t e_resp;
        logic  mem_req_d;
        mem_req_d = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            got_req = {mem_we, mem_addr, mem_wdata, mem_wstrb};
            if (mem_req && !mem_req_d) begin
                held = got_req;
                n_cmp++;
                if (exp_req_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL mem_req: unexpected request we=%0b addr=%h", mem_we, mem_addr);
                end else begin
                    e_req = exp_req_q.pop_front();
                    if (got_req.we !== e_req.we || got_req.addr !== e_req.addr ||
                        got_req.wstrb !== e_req.wstrb || (e_req.we && got_req.wdata !== e_req.wdata)) begin
                        n_bad++;
                        $display("FAIL mem_req: got we=%0b addr=%h wdata=%h wstrb=%b expected we=%0b addr=%h wdata=%h wstrb=%b",
                                 got_req.we, got_req.addr, got_req.wdata, got_req.wstrb,
                                 e_req.we, e_req.addr, e_req.wdata, e_req.wstrb);
                    end else begin
                        $display("req  we=%0b addr=%h wdata=%h wstrb=%b", mem_we, mem_addr, mem_wdata, mem_wstrb);
                    end
                end
            end else if (mem_req && mem_req_d) begin
                n_cmp++;
                if (got_req !== held) begin
                    n_bad++;
                    $display("FAIL mem_frozen: got %h expected %h", got_req, held);
                end
            end
            if (if_ready || d_ready || bus_err) begin
                got_resp = {if_ready, d_ready, bus_err, if_ready ? if_rdata : (d_ready ? d_rdata : 32'h0)};
                n_cmp++;
                if (exp_resp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL resp: unexpected if_ready=%0b d_ready=%0b bus_err=%0b", if_ready, d_ready, bus_err);
                end else begin
                    e_resp = exp_resp_q.pop_front();
                    if (got_resp !== e_resp) begin
                        n_bad++;
                        $display("FAIL resp: got if/d/err=%0b%0b%0b rdata=%h expected if/d/err=%0b%0b%0b rdata=%h",
                                 got_resp.if_rdy, got_resp.d_rdy, got_resp.err, got_resp.rdata,
                                 e_resp.if_rdy, e_resp.d_rdy, e_resp.err, e_resp.rdata);
                    end else begin
                        $display("resp if/d/err=%0b%0b%0b rdata=%h", if_ready, d_ready, bus_err, got_resp.rdata);
                    end
                end
            end
            mem_req_d = mem_req;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        int   cnt;
        logic stall_ok;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (2) tick();
        check("reset_mem_ctrl", {mem_req, mem_we, mem_wstrb, mem_addr}, '0);
        check("reset_mem_wdata", mem_wdata, '0);
        check("reset_pulses", {if_ready, d_ready, bus_err}, '0);
        check("reset_rdata", {if_rdata, d_rdata}, '0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: single fetch, ack on first mem_req cycle
        ack_delay = 0;
        exp_req(1'b0, 32'h100, 32'h0, 4'h0);
        exp_resp(1'b1, 1'b0, 1'b0, 32'h0050_0093);
        if_req = 1'b1; if_addr = 32'h100;
        #1 check("t1_if_stall", if_stall, 1);
        wait_pulse(0, 10, "t1_if_ready", k);
        check("t1_latency", k, 3);
        if_req = 1'b0;
        repeat (2) tick();

        // 2: simultaneous fetch and data read; data goes first
        ack_delay = 1;
        exp_req(1'b0, 32'h2000, 32'h0, 4'h0);
        exp_req(1'b0, 32'h0, 32'h0, 4'h0);
        exp_resp(1'b0, 1'b1, 1'b0, 32'h1111_2222);
        exp_resp(1'b1, 1'b0, 1'b0, 32'h0000_0013);
        if_req = 1'b1; if_addr = 32'h0; d_rd = 1'b1; d_addr = 32'h2000;
        stall_ok = 1'b1; k = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (d_ready) begin
                k = c;
                break;
            end
            if (!if_stall) stall_ok = 1'b0;
        end
        check("t2_d_ready_cycle", k, 4);
        check("t2_if_stall_held", stall_ok, 1);
        d_rd = 1'b0;
        wait_pulse(0, 20, "t2_if_ready", k);
        check("t2_fetch_after_data", k, 3);
        if_req = 1'b0;
        repeat (2) tick();

        // 5: data read never acked -> timeout after 8 busy cycles
        ack_delay = -1;
        exp_req(1'b0, 32'h80, 32'h0, 4'h0);
        exp_resp(1'b0, 1'b1, 1'b1, 32'h0);
        d_rd = 1'b1; d_addr = 32'h80;
        #1 check("t5_d_stall", d_stall, 1);
        cnt = 0; k = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (d_ready) begin
                k = c;
                break;
            end
            if (mem_req) cnt++;
        end
        check("t5_busy_cycles", cnt, 8);
        check("t5_ready_cycle", k, 10);
        check("t5_bus_err_with_ready", bus_err, 1);
        d_rd = 1'b0;
        repeat (2) tick();

        // 6: reset during BUSY_D, then the held read is reissued
        ack_delay = -1;
        exp_req(1'b0, 32'h2000, 32'h0, 4'h0);
        exp_req(1'b0, 32'h2000, 32'h0, 4'h0);
        exp_resp(1'b0, 1'b1, 1'b0, 32'h1111_2222);
        d_rd = 1'b1; d_addr = 32'h2000;
        repeat (3) tick();
        check("t6_busy_before_reset", mem_req, 1);
        #1 rst_n = 1'b0;
        #1 check("t6_reset_drop", {mem_req, d_ready, bus_err}, '0);
        ack_delay = 1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_pulse(1, 20, "t6_reissue", k);
        check("t6_reissue_latency", k, 4);
        d_rd = 1'b0;
        repeat (2) tick();

        // 3: fetch flushed in flight; handshake completes silently, then refetch
        ack_delay = 4;
        exp_req(1'b0, 32'h300, 32'h0, 4'h0);
        exp_req(1'b0, 32'h400, 32'h0, 4'h0);
        exp_resp(1'b1, 1'b0, 1'b0, 32'h00A0_0113);
        if_req = 1'b1; if_addr = 32'h300;
        repeat (2) tick();
        flush = 1'b1; if_addr = 32'h400;
        tick();
        flush = 1'b0;
        tick();
        check("t3_req_held_in_drop", {mem_req, mem_addr}, {1'b1, 32'h300});
        wait_pulse(0, 20, "t3_refetch", k);
        check("t3_refetch_cycle", k, 9);
        if_req = 1'b0;
        repeat (2) tick();

        // 7: flushed fetch never acked -> silent bus_err only
        ack_delay = -1;
        exp_req(1'b0, 32'h500, 32'h0, 4'h0);
        exp_resp(1'b0, 1'b0, 1'b1, 32'h0);
        if_req = 1'b1; if_addr = 32'h500;
        repeat (2) tick();
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        wait_pulse(2, 20, "t7_drop_timeout", k);
        check("t7_err_cycle", k, 9);
        check("t7_no_if_ready", if_ready, 0);
        repeat (2) tick();

        // 4: data write, fields frozen while inputs change
        ack_delay = 3;
        exp_req(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011);
        exp_resp(1'b0, 1'b1, 1'b0, 32'h0);
        d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        repeat (2) tick();
        d_addr = 32'h44; d_wdata = 32'h1234_5678; d_wstrb = 4'b1100;
        tick();
        check("t4_fields_frozen", {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata},
              {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF});
        wait_pulse(1, 20, "t4_d_ready", k);
        check("t4_d_rdata_zero", d_rdata, 0);
        d_wr = 1'b0;
        repeat (3) tick();

        check("exp_req_left", exp_req_q.size(), 0);
        check("exp_resp_left", exp_resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
